fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Sequences the instruction-fetch PC register: drives its npc/WE pair and picks
//  sequential, branch and jump successors. Applies hazard stalls and holds a
//  redirect that arrives during a stall. Halts fetch on an out-of-range or
//  misaligned PC. Sits between the hazard/branch logic and the fetch unit.
// PARAMETERS
//  RESET_PC    32'h0000_3000  boot address; also the base of instruction memory
//  IMEM_WORDS  8192           instruction-memory depth in words; legal PC < RESET_PC+4*IMEM_WORDS
//  DELAY_SLOT  1              1: no bubble after a redirect; 0: one bubble (if_valid=0)
// PORTS
//  clk            in   1   clock, rising edge
//  reset          in   1   asynchronous, active-low reset (0 = reset)
//  pc_in          in   32  current PC from the fetch unit
//  stall          in   1   hazard stall; freeze the PC this cycle
//  br_taken       in   1   branch resolved taken this cycle
//  br_target      in   32  branch target
//  jmp            in   1   jump/jr this cycle
//  jmp_target     in   32  jump target
//  npc            out  32  next PC to the fetch unit
//  pc_we          out  1   PC write enable to the fetch unit
//  if_valid       out  1   the instruction at pc_in is valid for decode
//  redirect_pend  out  1   a redirect is latched and waiting for the stall to clear
//  fetch_err      out  1   sticky fetch fault; fetch is halted
// BEHAVIOUR
//  Reset (async assert, any state): state=BOOT, npc=RESET_PC, pc_we=1, if_valid=0,
//   redirect_pend=0, fetch_err=0, pending target=0.
//  FSM states: BOOT, RUN, HOLD, BUBBLE, HALT. All outputs are registered except npc/pc_we.
//  BOOT: lasts exactly 1 cycle after reset deasserts. npc=RESET_PC, pc_we=1,
//   if_valid=0. Next state is RUN.
//  Request priority, highest first: fetch fault > stall > jmp > br_taken > pending > sequential.
//  RUN, no stall: pc_we=1, if_valid=1.
//   - jmp: npc=jmp_target.
//   - else br_taken: npc=br_target.
//   - else: npc=pc_in+4. Wraps mod 2^32; the range check then faults.
//   - On a redirect with DELAY_SLOT=0, go to BUBBLE. Otherwise stay in RUN.
//  RUN/HOLD with stall=1: pc_we=0, npc=pc_in, if_valid holds its prior value. State is HOLD.
//   - A jmp/br_taken seen while stalled stores its target (jmp wins).
//   - That sets redirect_pend=1 on the next edge.
//   - A later redirect during the same stall overwrites the stored target.
//  HOLD with stall=0:
//   - If redirect_pend=1: npc=stored target, pc_we=1, redirect_pend clears.
//     Same-cycle jmp/br_taken inputs take priority over the stored target.
//   - Otherwise behave as RUN. Exit to RUN, or to BUBBLE if a redirect fires and DELAY_SLOT=0.
//  BUBBLE: if_valid=0 for 1 cycle and the PC advances normally (pc_we=1, npc=pc_in+4).
//   stall extends the bubble. Next state is RUN.
//  Fetch fault:
//   - Trigger: the npc about to be written has npc[1:0]!=0, or npc<RESET_PC,
//     or npc>=RESET_PC+4*IMEM_WORDS.
//   - Then pc_we=0 in that cycle and the next state is HALT.
//  HALT: fetch_err=1, if_valid=0, pc_we=0, npc=pc_in. Only reset leaves HALT.
//  Range compare is 33-bit unsigned, so the upper bound cannot overflow.
//  Combinational path: stall/br/jmp to npc/pc_we only; there is no path from pc_in to if_valid.
// TESTING
//  1. Release reset -> BOOT cycle npc=0x3000, pc_we=1. Then pc_in steps 3000,3004,3008 with if_valid=1.
//  2. At pc_in=0x3010 assert br_taken, br_target=0x3100.
//     -> next pc_in=0x3100; if_valid stays 1 when DELAY_SLOT=1.
//     -> with DELAY_SLOT=0, one cycle of if_valid=0 first.
//  3. stall for 3 cycles -> pc_we=0, pc_in frozen. jmp to 0x3200 in stall cycle 2
//     -> redirect_pend=1 -> first unstalled cycle npc=0x3200, then redirect_pend=0.
//  4. jmp and br_taken in the same cycle (0x3300/0x3400) -> npc=0x3300.
//  5. br_target=0x3102 -> pc_we=0, fetch_err=1, if_valid=0, held until reset.
//     Sequential step from 0x3000+4*8191-4 to the end of IMEM also faults.
//  6. Assert reset while in HOLD with redirect_pend=1
//     -> immediately redirect_pend=0, state BOOT; after release pc_in restarts at 0x3000.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch PC sequencer: picks the successor PC, handles stalls and held redirects,
// inserts optional redirect bubbles and halts on an illegal fetch address.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter int unsigned IMEM_WORDS = 8192,
  parameter bit          DELAY_SLOT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  output logic [31:0] npc,
  output logic        pc_we,
  output logic        if_valid,
  output logic        redirect_pend,
  output logic        fetch_err
);

  typedef enum logic [2:0] {StBoot, StRun, StHold, StBubble, StHalt} state_e;

  // 33-bit bounds so the top of instruction memory cannot wrap.
  localparam logic [32:0] IMEM_LO = {1'b0, RESET_PC};
  localparam logic [32:0] IMEM_HI = IMEM_LO + ({1'b0, 32'(IMEM_WORDS)} << 2);

  state_e      state_q, state_d;
  logic        if_valid_q, if_valid_d;
  logic        pend_q, pend_d;
  logic [31:0] ptgt_q, ptgt_d;
  logic        err_q, err_d;

  logic [31:0] cand;
  logic        advance;
  logic        redirect;
  logic        fault;

  always_comb begin
    state_d    = state_q;
    if_valid_d = if_valid_q;
    pend_d     = pend_q;
    ptgt_d     = ptgt_q;
    err_d      = err_q;
    npc        = pc_in;
    pc_we      = 1'b0;
    cand       = pc_in + 32'd4;
    advance    = 1'b0;
    redirect   = 1'b0;
    fault      = 1'b0;

    case (state_q)
      StBoot: begin
        npc        = RESET_PC;
        pc_we      = 1'b1;
        state_d    = StRun;
        if_valid_d = 1'b1;
      end
      StRun, StHold: begin
        if (stall) begin
          state_d = StHold;
          if (jmp || br_taken) begin
            pend_d = 1'b1;
            ptgt_d = jmp ? jmp_target : br_target;
          end
        end else begin
          advance = 1'b1;
          if (jmp) begin
            cand     = jmp_target;
            redirect = 1'b1;
          end else if (br_taken) begin
            cand     = br_target;
            redirect = 1'b1;
          end else if (pend_q) begin
            cand     = ptgt_q;
            redirect = 1'b1;
          end
        end
      end
      StBubble: begin
        // A stall simply stretches the bubble; redirects are not taken here.
        advance = !stall;
      end
      StHalt: begin
        if_valid_d = 1'b0;
      end
      default: begin
        state_d = StBoot;
      end
    endcase

    if (advance) begin
      fault = (cand[1:0] != 2'b00) || ({1'b0, cand} < IMEM_LO) || ({1'b0, cand} >= IMEM_HI);
      pend_d = 1'b0;
      if (fault) begin
        state_d    = StHalt;
        err_d      = 1'b1;
        if_valid_d = 1'b0;
      end else begin
        npc   = cand;
        pc_we = 1'b1;
        if (redirect && !DELAY_SLOT) begin
          state_d    = StBubble;
          if_valid_d = 1'b0;
        end else begin
          state_d    = StRun;
          if_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StBoot;
      if_valid_q <= 1'b0;
      pend_q     <= 1'b0;
      ptgt_q     <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      if_valid_q <= if_valid_d;
      pend_q     <= pend_d;
      ptgt_q     <= ptgt_d;
      err_q      <= err_d;
    end
  end

  assign if_valid      = if_valid_q;
  assign redirect_pend = pend_q;
  assign fetch_err     = err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer: two instances (DELAY_SLOT 1 and 0) each paired with a
// modelled fetch-unit PC register and compared against a behavioural reference model.
module tb_fetch_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam int unsigned WORDS    = 8192;
  localparam logic [31:0] IMEM_END = RESET_PC + 32'(WORDS * 4);

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0, br_taken = 1'b0, jmp = 1'b0;
  logic [31:0] br_target = '0, jmp_target = '0;
  logic [31:0] pc_in0 = '0, pc_in1 = '0;
  logic [31:0] npc0, npc1;
  logic        we0, we1, val0, val1, pend0, pend1, err0, err1;

  always #5 clk = ~clk;

  fetch_sequencer #(.RESET_PC(RESET_PC), .IMEM_WORDS(WORDS), .DELAY_SLOT(1'b0)) u_dut_ds0 (
    .clk(clk), .reset(reset), .pc_in(pc_in0), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .jmp(jmp), .jmp_target(jmp_target), .npc(npc0), .pc_we(we0),
    .if_valid(val0), .redirect_pend(pend0), .fetch_err(err0)
  );

  fetch_sequencer #(.RESET_PC(RESET_PC), .IMEM_WORDS(WORDS), .DELAY_SLOT(1'b1)) u_dut_ds1 (
    .clk(clk), .reset(reset), .pc_in(pc_in1), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .jmp(jmp), .jmp_target(jmp_target), .npc(npc1), .pc_we(we1),
    .if_valid(val1), .redirect_pend(pend1), .fetch_err(err1)
  );

  // Reference model, index = DELAY_SLOT value. m_pc is the fetch unit's PC register.
  bit          m_boot[2], m_halt[2], m_bubble[2], m_valid[2], m_pend[2];
  logic [31:0] m_ptgt[2], m_pc[2];

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic bit illegal(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < RESET_PC) || (64'(a) >= 64'(RESET_PC) + 64'(WORDS) * 4);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_boot[i] = 1; m_halt[i] = 0; m_bubble[i] = 0; m_valid[i] = 0;
      m_pend[i] = 0; m_ptgt[i] = '0;
    end
  endtask

  task automatic check_outputs(input int i, input bit chk_npc, input logic [31:0] e_npc,
                               input bit e_we);
    string sfx;
    sfx = (i == 0) ? "_ds0" : "_ds1";
    if (chk_npc) check({"npc", sfx}, (i == 0) ? npc0 : npc1, e_npc);
    check({"pc_we", sfx}, 32'((i == 0) ? we0 : we1), 32'(e_we));
    check({"if_valid", sfx}, 32'((i == 0) ? val0 : val1), 32'(m_valid[i]));
    check({"fetch_err", sfx}, 32'((i == 0) ? err0 : err1), 32'(m_halt[i]));
    if (!m_halt[i]) check({"redirect_pend", sfx}, 32'((i == 0) ? pend0 : pend1), 32'(m_pend[i]));
  endtask

  task automatic cycle(input bit s, input bit b, input logic [31:0] bt, input bit j,
                       input logic [31:0] jt);
    logic [31:0] tgt, e_npc;
    bit          e_we, chk_npc, redir;
    @(negedge clk);
    reset = 1'b1;
    stall = s; br_taken = b; br_target = bt; jmp = j; jmp_target = jt;
    pc_in0 = m_pc[0]; pc_in1 = m_pc[1];
    #1;
    for (int i = 0; i < 2; i++) begin
      chk_npc = 1; e_we = 0; e_npc = m_pc[i];
      if (m_boot[i]) begin
        e_npc = RESET_PC; e_we = 1;
      end else if (m_halt[i] || s) begin
        e_npc = m_pc[i];
      end else begin
        redir = !m_bubble[i] && (j || b || m_pend[i]);
        if (m_bubble[i]) tgt = m_pc[i] + 4;
        else if (j) tgt = jt;
        else if (b) tgt = bt;
        else if (m_pend[i]) tgt = m_ptgt[i];
        else tgt = m_pc[i] + 4;
        if (illegal(tgt)) chk_npc = 0;
        else begin
          e_npc = tgt; e_we = 1;
        end
      end
      check_outputs(i, chk_npc, e_npc, e_we);
      // advance the model
      if (m_boot[i]) begin
        m_boot[i] = 0; m_valid[i] = 1; m_pc[i] = RESET_PC;
      end else if (m_halt[i]) begin
        m_valid[i] = 0;
      end else if (s) begin
        if (!m_bubble[i] && (j || b)) begin
          m_pend[i] = 1; m_ptgt[i] = j ? jt : bt;
        end
      end else if (!e_we) begin
        m_halt[i] = 1; m_valid[i] = 0; m_pend[i] = 0;
      end else begin
        m_pc[i] = tgt; m_pend[i] = 0;
        m_bubble[i] = redir && (i == 0);
        m_valid[i] = !m_bubble[i];
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, 0, '0, 0, '0);
  endtask

  // Assert reset mid-cycle; outputs must take their reset values without waiting for an edge.
  task automatic apply_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) check_outputs(i, 1, RESET_PC, 1);
  endtask

  function automatic logic [31:0] rand_tgt();
    int r;
    r = $urandom_range(0, 99);
    if (r < 80) return RESET_PC + 32'(4 * $urandom_range(0, WORDS - 1));
    else if (r < 88) return IMEM_END - 32'(4 * $urandom_range(1, 3));
    else if (r < 94) return RESET_PC + 32'(4 * $urandom_range(0, WORDS - 1)) + 32'($urandom_range(1, 3));
    else return $urandom();
  endfunction

  initial begin
    model_reset();
    m_pc[0] = '0; m_pc[1] = '0;
    apply_reset();
    // boot, then 3000..300c sequential
    idle(5);
    cycle(0, 1, 32'h3100, 0, '0);          // branch at 0x3010
    idle(2);
    cycle(1, 0, '0, 0, '0);
    cycle(1, 0, '0, 1, 32'h3200);          // jump during stall cycle 2
    cycle(1, 0, '0, 0, '0);
    idle(3);
    cycle(0, 1, 32'h3400, 1, 32'h3300);    // jmp beats br_taken
    idle(2);
    cycle(1, 1, 32'h3500, 0, '0);          // stored target overwritten by later redirect
    cycle(1, 0, '0, 1, 32'h3600);
    cycle(0, 0, '0, 0, '0);
    idle(2);
    cycle(0, 1, 32'h3102, 0, '0);          // misaligned -> halt
    idle(3);
    cycle(0, 1, 32'h3000, 1, 32'h3000);    // redirect ignored while halted
    apply_reset();
    idle(1);
    cycle(0, 0, '0, 1, IMEM_END - 8);
    idle(4);                               // steps off the end of IMEM
    apply_reset();
    idle(2);
    cycle(1, 0, '0, 1, 32'h3800);
    cycle(1, 0, '0, 0, '0);
    apply_reset();                         // reset while holding a pending redirect
    idle(3);

    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 99) == 0) apply_reset();
      else cycle($urandom_range(0, 99) < 25, $urandom_range(0, 99) < 12, rand_tgt(),
                 $urandom_range(0, 99) < 8, rand_tgt());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
